// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Shared types and constants for the still-capture path: the capture FSM
// state encoding, default frame geometry / decimation, coordinate and
// counter widths, and small helpers used by the sequencer.
// ----------------------------------------------------------------------------
package video_pkg;

   // Frame-buffer coordinate width (8-bit addressed rows and columns)
   localparam int unsigned COORD_W = 8;

   // Raw pixel/line counter width; counters saturate rather than wrap
   localparam int unsigned CNT_W = 11;

   // Default geometry and decimation
   localparam int unsigned DEF_WIDTH   = 160;
   localparam int unsigned DEF_HEIGHT  = 120;
   localparam int unsigned DEF_H_DECIM = 4;
   localparam int unsigned DEF_V_DECIM = 4;
   localparam int unsigned DEF_TIMEOUT = 2_000_000;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_SYNC  = 3'd1,
      S_WAIT_FRAME = 3'd2,
      S_CAPTURE    = 3'd3,
      S_DONE       = 3'd4,
      S_READ       = 3'd5
   } capture_state_t;

   // Increment that sticks at all-ones
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
// Registers one synchronous sync input and flags its edges by comparing the
// registered value with the previous registered value. The rise/fall pulses
// are decoded from flops only, so an edge on the pin is visible in the
// second cycle after it and acted on by a consumer at the following edge.
//
// Ports
//   clk    : system clock
//   reset  : synchronous, active-high; both stages load IDLE_LEVEL
//   sync   : sync input, already in the clk domain
//   rise   : one-cycle pulse on a 0->1 transition
//   fall   : one-cycle pulse on a 1->0 transition
// ----------------------------------------------------------------------------
module sync_edge_det #(
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic sync,
   output logic rise,
   output logic fall
);

   logic sync_q;
   logic sync_prev;

   // Both stages reset to the inactive level so no edge is seen out of reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= IDLE_LEVEL;
         sync_prev <= IDLE_LEVEL;
      end else begin
         sync_q    <= sync;
         sync_prev <= sync_q;
      end
   end

   assign rise = sync_q & ~sync_prev;
   assign fall = ~sync_q & sync_prev;

endmodule

// File: rtl/still_capture_ctrl.sv
// ----------------------------------------------------------------------------
// still_capture_ctrl
// Captures exactly one decimated frame from the camera stream into the shared
// frame buffer, then arbitrates the buffer to the CV reader.
//
// A capture request arms on the next VS fall, starts counting at the VS rise,
// emits decimated write strobes with (x,y) until the next VS fall, then marks
// the buffer valid. The reader gets the buffer through rd_req/rd_gnt while a
// valid frame is held; a capture request arriving while the reader owns the
// buffer (or while a frame is being closed) is remembered and served later.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   start        : capture request (level sampled)
//   iVGA_VS/HS   : active-low vertical / horizontal sync
//   pix_valid    : pixel present this cycle
//   rd_req       : reader wants the buffer, held until it is finished
//   rd_gnt       : buffer granted to the reader
//   write, x, y  : frame-buffer write strobe and coordinates
//   busy         : capture in progress (not idle, not reading)
//   done         : one-cycle pulse when the frame is complete
//   frame_valid  : buffer holds a complete frame
//   timeout_err  : one-cycle pulse on a sync-wait watchdog abort
// ----------------------------------------------------------------------------
module still_capture_ctrl
   import video_pkg::*;
#(
   parameter int unsigned H_DECIM = DEF_H_DECIM,
   parameter int unsigned V_DECIM = DEF_V_DECIM,
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned HEIGHT  = DEF_HEIGHT,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               iVGA_VS,
   input  logic               iVGA_HS,
   input  logic               pix_valid,
   input  logic               rd_req,
   output logic               rd_gnt,
   output logic               write,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               busy,
   output logic               done,
   output logic               frame_valid,
   output logic               timeout_err
);

   localparam int unsigned H_SH = $clog2(H_DECIM);
   localparam int unsigned V_SH = $clog2(V_DECIM);
   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] H_MASK  = CNT_W'(H_DECIM - 1);
   localparam logic [CNT_W-1:0] V_MASK  = CNT_W'(V_DECIM - 1);
   localparam logic [CNT_W-1:0] W_LIM   = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(HEIGHT);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

   // Parameter sanity: decimation is done by shifting, coordinates are 8 bits
   if (!is_pow2(H_DECIM)) begin : g_bad_h_decim
      $error("still_capture_ctrl: H_DECIM must be a power of two");
   end
   if (!is_pow2(V_DECIM)) begin : g_bad_v_decim
      $error("still_capture_ctrl: V_DECIM must be a power of two");
   end
   if (WIDTH == 0 || WIDTH > 256) begin : g_bad_width
      $error("still_capture_ctrl: WIDTH must be 1..256");
   end
   if (HEIGHT == 0 || HEIGHT > 256) begin : g_bad_height
      $error("still_capture_ctrl: HEIGHT must be 1..256");
   end
   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("still_capture_ctrl: TIMEOUT must be at least 1");
   end

   // ------------------------------------------------------------------
   // Sync edge detection
   // ------------------------------------------------------------------
   logic vs_rise;
   logic vs_fall;
   logic hs_rise;
   logic hs_fall_unused;

   sync_edge_det #(.IDLE_LEVEL(1'b1)) u_vs_edge (
      .clk   (clk),
      .reset (reset),
      .sync  (iVGA_VS),
      .rise  (vs_rise),
      .fall  (vs_fall)
   );

   sync_edge_det #(.IDLE_LEVEL(1'b1)) u_hs_edge (
      .clk   (clk),
      .reset (reset),
      .sync  (iVGA_HS),
      .rise  (hs_rise),
      .fall  (hs_fall_unused)
   );

   // ------------------------------------------------------------------
   // State and counters
   // ------------------------------------------------------------------
   capture_state_t   state;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             first_line;
   logic [WD_W-1:0]  wd_cnt;
   logic             start_pending;

   // Position of the pixel sampled this cycle. An HS rise in the same cycle
   // starts a new line, so that pixel is column 0 of the next row.
   logic [CNT_W-1:0] h_eff;
   logic [CNT_W-1:0] v_eff;
   logic             wr_hit;
   logic             wd_expired;

   always_comb begin
      h_eff      = hs_rise ? '0 : h_cnt;
      v_eff      = (hs_rise && !first_line) ? sat_inc(v_cnt) : v_cnt;
      wr_hit     = pix_valid
                   && ((h_eff & H_MASK) == '0)
                   && ((v_eff & V_MASK) == '0)
                   && ((h_eff >> H_SH) < W_LIM)
                   && ((v_eff >> V_SH) < H_LIM);
      wd_expired = (wd_cnt == WD_LAST);
   end

   // Capture sequencer, counters, watchdog and reader arbitration
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         h_cnt         <= '0;
         v_cnt         <= '0;
         first_line    <= 1'b0;
         wd_cnt        <= '0;
         start_pending <= 1'b0;
         rd_gnt        <= 1'b0;
         write         <= 1'b0;
         x             <= '0;
         y             <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         frame_valid   <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         write       <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;

         case (state)
            S_IDLE: begin
               // A waiting reader with a valid frame wins over a new capture
               if (rd_req && frame_valid) begin
                  state  <= S_READ;
                  rd_gnt <= 1'b1;
                  if (start) begin
                     start_pending <= 1'b1;
                  end
               end else if (start || start_pending) begin
                  state         <= S_WAIT_SYNC;
                  start_pending <= 1'b0;
                  frame_valid   <= 1'b0;
                  wd_cnt        <= '0;
                  busy          <= 1'b1;
               end
            end

            S_WAIT_SYNC: begin
               if (vs_fall) begin
                  state  <= S_WAIT_FRAME;
                  wd_cnt <= '0;
               end else if (wd_expired) begin
                  state         <= S_IDLE;
                  busy          <= 1'b0;
                  timeout_err   <= 1'b1;
                  start_pending <= 1'b0;
                  wd_cnt        <= '0;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end

            S_WAIT_FRAME: begin
               if (vs_rise) begin
                  state      <= S_CAPTURE;
                  h_cnt      <= '0;
                  v_cnt      <= '0;
                  first_line <= 1'b1;
                  wd_cnt     <= '0;
               end else if (wd_expired) begin
                  state         <= S_IDLE;
                  busy          <= 1'b0;
                  timeout_err   <= 1'b1;
                  start_pending <= 1'b0;
                  wd_cnt        <= '0;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end

            S_CAPTURE: begin
               // The first HS rise of the frame opens row 0 without counting
               if (hs_rise) begin
                  h_cnt <= pix_valid ? CNT_W'(1) : '0;
                  if (first_line) begin
                     first_line <= 1'b0;
                  end else begin
                     v_cnt <= sat_inc(v_cnt);
                  end
               end else if (pix_valid) begin
                  h_cnt <= sat_inc(h_cnt);
               end

               if (wr_hit) begin
                  write <= 1'b1;
                  x     <= COORD_W'(h_eff >> H_SH);
                  y     <= COORD_W'(v_eff >> V_SH);
               end

               if (vs_fall) begin
                  state       <= S_DONE;
                  done        <= 1'b1;
                  frame_valid <= 1'b1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               if (start) begin
                  start_pending <= 1'b1;
               end
            end

            S_READ: begin
               if (start) begin
                  start_pending <= 1'b1;
               end
               // Reader finished: the buffer contents are no longer owned
               if (!rd_req) begin
                  state       <= S_IDLE;
                  rd_gnt      <= 1'b0;
                  frame_valid <= 1'b0;
               end
            end

            default: begin
               state  <= S_IDLE;
               busy   <= 1'b0;
               rd_gnt <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_still_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_still_capture_ctrl
// Directed bench for still_capture_ctrl. Two instances share the stimulus:
// dut1 with the default 160x120 bound and dut2 with WIDTH=2 for clipping.
// Both use 4x4 decimation and a 50-clock sync watchdog.
// ----------------------------------------------------------------------------
module tb_still_capture_ctrl;

   logic clk;
   logic reset;
   logic start;
   logic vs;
   logic hs;
   logic pix_valid;
   logic rd_req;

   logic       rd_gnt1, write1, busy1, done1, fv1, to1;
   logic [7:0] x1, y1;
   logic       rd_gnt2, write2, busy2, done2, fv2, to2;
   logic [7:0] x2, y2;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   logic [15:0] wq1[$];
   logic [15:0] wq2[$];

   still_capture_ctrl #(
      .H_DECIM(4), .V_DECIM(4), .WIDTH(160), .HEIGHT(120), .TIMEOUT(50)
   ) dut1 (
      .clk(clk), .reset(reset), .start(start), .iVGA_VS(vs), .iVGA_HS(hs),
      .pix_valid(pix_valid), .rd_req(rd_req), .rd_gnt(rd_gnt1),
      .write(write1), .x(x1), .y(y1), .busy(busy1), .done(done1),
      .frame_valid(fv1), .timeout_err(to1)
   );

   still_capture_ctrl #(
      .H_DECIM(4), .V_DECIM(4), .WIDTH(2), .HEIGHT(120), .TIMEOUT(50)
   ) dut2 (
      .clk(clk), .reset(reset), .start(start), .iVGA_VS(vs), .iVGA_HS(hs),
      .pix_valid(pix_valid), .rd_req(rd_req), .rd_gnt(rd_gnt2),
      .write(write2), .x(x2), .y(y2), .busy(busy2), .done(done2),
      .frame_valid(fv2), .timeout_err(to2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write / done monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (write1) wq1.push_back({x1, y1});
      if (write2) wq2.push_back({x2, y2});
      if (done1)  done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // VS low then high: arms the capture and opens the frame
   task automatic vs_frame_start();
      vs = 1'b0;
      ticks(4);
      vs = 1'b1;
      ticks(4);
   endtask

   task automatic vs_frame_end();
      vs = 1'b0;
      ticks(4);
      vs = 1'b1;
      ticks(4);
   endtask

   // HS pulse, settle, then npix back-to-back pixels
   task automatic drive_line(input int npix, input bit chk_first);
      hs = 1'b0;
      ticks(2);
      hs = 1'b1;
      ticks(3);
      for (int i = 0; i < npix; i++) begin
         pix_valid = 1'b1;
         tick();
         if (i == 0 && chk_first) begin
            check("first_write_latency", {write1, x1, y1}, {1'b1, 8'd0, 8'd0});
         end
      end
      pix_valid = 1'b0;
      ticks(2);
   endtask

   task automatic drive_frame();
      vs_frame_start();
      for (int l = 0; l < 8; l++) drive_line(16, l == 0);
      vs_frame_end();
   endtask

   // 8 lines x 16 pixels, 4x4 decimation: rows 0,1 and columns 0..3 (0..1 on dut2)
   task automatic check_frame(input int b1, input int b2);
      logic [15:0] got;
      check("n_writes", 32'(wq1.size() - b1), 32'd8);
      for (int i = 0; i < 8; i++) begin
         got = (b1 + i < wq1.size()) ? wq1[b1 + i] : 16'hffff;
         check("wr_xy", 32'(got), 32'(((i % 4) << 8) | (i / 4)));
      end
      check("n_writes_clip", 32'(wq2.size() - b2), 32'd4);
      for (int i = 0; i < 4; i++) begin
         got = (b2 + i < wq2.size()) ? wq2[b2 + i] : 16'hffff;
         check("wr_xy_clip", 32'(got), 32'(((i % 2) << 8) | (i / 2)));
      end
   endtask

   initial begin
      int b1;
      int b2;
      int d0;
      int bad;

      reset = 1'b1; start = 1'b0; vs = 1'b1; hs = 1'b1;
      pix_valid = 1'b0; rd_req = 1'b0;
      ticks(3);
      reset = 1'b0;
      tick();

      // Reset values
      check("rst_write", 32'(write1), 32'd0);
      check("rst_x", 32'(x1), 32'd0);
      check("rst_y", 32'(y1), 32'd0);
      check("rst_rd_gnt", 32'(rd_gnt1), 32'd0);
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_done", 32'(done1), 32'd0);
      check("rst_frame_valid", 32'(fv1), 32'd0);
      check("rst_timeout_err", 32'(to1), 32'd0);
      check("rst_dut2", 32'({write2, x2, y2, rd_gnt2, busy2, done2, fv2, to2}), 32'd0);

      // start + rd_req with no valid frame: capture wins; VS held high -> watchdog
      start = 1'b1; rd_req = 1'b1;
      tick();
      start = 1'b0;
      check("wd_busy_enter", 32'(busy1), 32'd1);
      check("wd_no_grant", 32'(rd_gnt1), 32'd0);
      bad = 0;
      for (int k = 1; k < 50; k++) begin
         tick();
         if (to1 || !busy1) bad++;
      end
      check("wd_quiet_49", 32'(bad), 32'd0);
      tick();
      check("wd_timeout_pulse", 32'(to1), 32'd1);
      check("wd_busy_clear", 32'(busy1), 32'd0);
      tick();
      check("wd_timeout_single", 32'(to1), 32'd0);
      check("wd_rdreq_waits", 32'(rd_gnt1), 32'd0);
      rd_req = 1'b0;
      tick();

      // Full-frame capture
      b1 = wq1.size(); b2 = wq2.size(); d0 = done_cnt;
      do_start();
      check("cap_busy", 32'(busy1), 32'd1);
      drive_frame();
      check_frame(b1, b2);
      check("cap_done_once", 32'(done_cnt - d0), 32'd1);
      check("cap_frame_valid", 32'(fv1), 32'd1);
      check("cap_busy_after", 32'(busy1), 32'd0);

      // Reader arbitration with simultaneous start
      start = 1'b1; rd_req = 1'b1;
      tick();
      start = 1'b0;
      check("arb_grant", 32'(rd_gnt1), 32'd1);
      check("arb_not_busy", 32'(busy1), 32'd0);
      b1 = wq1.size();
      ticks(3);
      check("arb_no_writes", 32'(wq1.size() - b1), 32'd0);
      check("arb_grant_held", 32'(rd_gnt1), 32'd1);
      rd_req = 1'b0;
      tick();
      check("arb_grant_drop", 32'(rd_gnt1), 32'd0);
      check("arb_fv_clear", 32'(fv1), 32'd0);
      tick();
      check("arb_pending_start", 32'(busy1), 32'd1);
      b1 = wq1.size(); b2 = wq2.size();
      drive_frame();
      check_frame(b1, b2);
      check("arb_frame_valid", 32'(fv1), 32'd1);

      // Reset during line 3
      do_start();
      vs_frame_start();
      for (int l = 0; l < 3; l++) drive_line(16, l == 0);
      hs = 1'b0;
      ticks(2);
      hs = 1'b1;
      ticks(3);
      pix_valid = 1'b1;
      ticks(5);
      reset = 1'b1;
      tick();
      check("rst_mid_write", 32'(write1), 32'd0);
      check("rst_mid_xy", 32'({x1, y1}), 32'd0);
      check("rst_mid_flags", 32'({rd_gnt1, busy1, done1, fv1, to1}), 32'd0);
      b1 = wq1.size();
      tick();
      reset = 1'b0;
      ticks(3);
      pix_valid = 1'b0;
      ticks(2);
      check("rst_mid_no_writes", 32'(wq1.size() - b1), 32'd0);
      check("rst_mid_idle", 32'(busy1), 32'd0);

      // Normal capture after the aborted one
      b1 = wq1.size(); b2 = wq2.size(); d0 = done_cnt;
      do_start();
      drive_frame();
      check_frame(b1, b2);
      check("post_rst_done", 32'(done_cnt - d0), 32'd1);
      check("post_rst_fv", 32'(fv1), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/still_capture_ctrl.md
# still_capture_ctrl

Sequencer and arbiter for single-frame still capture from the camera video stream into the shared 8-bit-addressed frame buffer. On request it arms on the next vertical sync and generates decimated write strobes and (x,y) coordinates for exactly one frame. It then hands the frame buffer to the CV reader through a request/grant handshake. It sits between the camera sync/pixel-valid signals, the frame-buffer write port and the downstream CV engine.

## Interface
- `H_DECIM`, default 4: horizontal decimation; one pixel kept per `H_DECIM` valid pixels.
- `V_DECIM`, default 4: vertical decimation; one line kept per `V_DECIM` lines.
- `WIDTH`, default 160: maximum stored x + 1; must be ≤ 256.
- `HEIGHT`, default 120: maximum stored y + 1; must be ≤ 256.
- `TIMEOUT`, default 2_000_000: clocks allowed in any sync-wait state before aborting.
- `clk` in 1: single system clock. All sync inputs are already in this domain.
- `reset` in 1: synchronous, active-high.
- `start` in 1: capture request, level-sampled.
- `iVGA_VS` in 1: vertical sync, active low.
- `iVGA_HS` in 1: horizontal sync, active low.
- `pix_valid` in 1: a pixel is present this cycle.
- `rd_req` in 1: CV reader requests the buffer; held until the reader is finished.
- `rd_gnt` out 1: buffer granted to the reader.
- `write` out 1: frame-buffer write strobe.
- `x` out 8: write column.
- `y` out 8: write row.
- `busy` out 1: a capture is in progress (any state other than S_IDLE or S_READ).
- `done` out 1: one-cycle pulse when the frame is complete.
- `frame_valid` out 1: the buffer holds a complete frame.
- `timeout_err` out 1: one-cycle pulse on a watchdog abort.

## Operation
- Input registration:
  - `iVGA_VS` and `iVGA_HS` are registered once.
  - Edges are detected by comparing the registered value against its previous value.
  - VS fall = frame sync start. VS rise = frame start. HS rise = line start.
- States:
  - S_IDLE:
    - If `rd_req` && `frame_valid`, go to S_READ. This takes priority over `start`.
    - Otherwise, if `start` or `start_pending`, go to S_WAIT_SYNC.
  - S_WAIT_SYNC: on VS fall, go to S_WAIT_FRAME. If the watchdog expires, go to S_IDLE.
  - S_WAIT_FRAME: on VS rise, clear the counters and go to S_CAPTURE. If the watchdog expires, go to S_IDLE.
  - S_CAPTURE:
    - `h_cnt` increments on each `pix_valid` and clears on HS rise.
    - `v_cnt` increments on each HS rise after the first in the frame.
    - On VS fall, go to S_DONE.
  - S_DONE: set `frame_valid`, pulse `done`, go to S_IDLE.
  - S_READ: `rd_gnt`=1. When `rd_req` falls, clear `frame_valid` and go to S_IDLE.
- Write rule (S_CAPTURE only):
  - `write`=1 when all of the following hold: `pix_valid`, `h_cnt % H_DECIM == 0`, `v_cnt % V_DECIM == 0`, `h_cnt/H_DECIM < WIDTH`, and `v_cnt/V_DECIM < HEIGHT`.
  - `x` = `h_cnt/H_DECIM`, `y` = `v_cnt/V_DECIM`, truncated to 8 bits.
  - Out-of-range pixels are silently dropped.
- Counter widths:
  - `h_cnt` and `v_cnt` are 11 bits and saturate at all-ones; they never wrap.
  - Decimation is a power-of-two shift. A non-power-of-two `H_DECIM` or `V_DECIM` is rejected by elaboration assertion.
- `start_pending`:
  - Set when `start` arrives in S_READ or S_DONE.
  - Cleared on entry to S_WAIT_SYNC.
  - `start` during any capture state is ignored.
- A new capture clears `frame_valid` on entry to S_WAIT_SYNC.
- Watchdog:
  - Counts clocks in S_WAIT_SYNC and S_WAIT_FRAME and resets on each state change.
  - On reaching `TIMEOUT`, pulses `timeout_err` and returns to S_IDLE. `start_pending` is cleared.

## Timing
- Reset values: `write`=0, `x`=0, `y`=0, `rd_gnt`=0, `busy`=0, `done`=0, `frame_valid`=0, `timeout_err`=0. The state is S_IDLE, and all counters and `start_pending` are 0.
- Reset mid-capture aborts in the next cycle. No further writes occur.
- Sync latency: a sync edge on the input pins is acted on 2 cycles later (1 register stage plus the edge compare).
- Write latency: `write`/`x`/`y` are registered and appear 1 cycle after the qualifying `pix_valid` sample.
- `rd_gnt` rises 1 cycle after S_IDLE sees `rd_req`. It falls in the cycle after `rd_req` falls.
- `done` is high for exactly 1 cycle, 1 cycle after the terminating VS fall is detected.
- Simultaneous `start` and `rd_req` in S_IDLE with `frame_valid`=1: the reader is granted and `start` becomes pending.
- Simultaneous `start` and `rd_req` with `frame_valid`=0: capture proceeds and `rd_req` waits.
- HS rise and `pix_valid` in the same cycle: the counter clear wins, and that pixel counts as `h_cnt`=0.

## Structure
- Package `video_pkg`:
  - State enum `capture_state_t`.
  - Default `WIDTH`/`HEIGHT`/decimation constants.
  - `COORD_W`=8.
- Sub-module `sync_edge_det`:
  - Registers one sync input and outputs `rise`/`fall` pulses.
  - Instanced twice, once for VS and once for HS.
- The top contains the FSM, counters, watchdog and arbitration.

## Test plan
- **Full-frame capture.** After reset, pulse `start`, then drive VS low→high, 8 lines of 16 `pix_valid` each with HS pulses, then VS low, with `H_DECIM`=`V_DECIM`=4. Required: exactly 8 writes at (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1); `done` pulses once; `frame_valid`=1.
- **Reader arbitration.** With `frame_valid`=1, raise `rd_req` and `start` together. Required: `rd_gnt`=1 next cycle and no writes. After `rd_req` drops, `rd_gnt` falls, capture starts from the pending request, and `frame_valid` clears.
- **Bounds clipping.** `WIDTH`=2 with a 16-pixel line. Required: only x=0,1 written per kept row.
- **Watchdog.** `TIMEOUT`=50, `start` with VS held high. Required: `timeout_err` pulses on cycle 50 of S_WAIT_SYNC, the FSM is back in S_IDLE, and `busy`=0.
- **Reset mid-capture.** Assert `reset` during line 3. Required: `write`=0 from the next cycle, all outputs at their reset values, and a later `start` captures normally.
